display_timings_param: RTL and testbench
========================================

// Module: display_timings_param
// PURPOSE
//  Parametrised raster timing generator; successor to the fixed 640x480p60 generator.
//  - Any mode via porch/sync/active parameters; sync polarity per axis.
//  - Pixel-clock enable for pixel repeat and slow modes.
//  - One-cycle frame/line start strobes.
//  - Registered, glitch-free sync/de aligned with sx/sy.
//  - Sits between the pixel clock domain and the pixel/pattern generators and TMDS/VGA output stage.
// PARAMETERS
//  CORDW   10   width of sx/sy; must hold H_TOTAL-1 and V_TOTAL-1
//  H_RES   640  active pixels per line
//  H_FP    16   horizontal front porch, pixels
//  H_SYNC  96   horizontal sync width, pixels
//  H_BP    48   horizontal back porch, pixels (>=1)
//  V_RES   480  active lines per frame
//  V_FP    10   vertical front porch, lines
//  V_SYNC  2    vertical sync width, lines
//  V_BP    33   vertical back porch, lines (>=1)
//  H_POL   0    hsync active level (0 = active-low)
//  V_POL   0    vsync active level (0 = active-low)
//  Derived: H_TOTAL=H_RES+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
// PORTS
//  clk_pix  in   1      pixel clock
//  rst      in   1      asynchronous reset, active-high
//  en       in   1      advance enable; counters and outputs hold when low
//  sx       out  CORDW  horizontal position, 0..H_TOTAL-1
//  sy       out  CORDW  vertical position, 0..V_TOTAL-1
//  hsync    out  1      horizontal sync, level per H_POL
//  vsync    out  1      vertical sync, level per V_POL
//  de       out  1      data enable: sx<H_RES && sy<V_RES
//  frame    out  1      one-cycle strobe on entry to (0,0)
//  line     out  1      one-cycle strobe on entry to (0,y), any y
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - sx=H_TOTAL-1, sy=V_TOTAL-1 (last pixel of back porch).
//   - de=0, hsync=~H_POL, vsync=~V_POL, frame=0, line=0.
//  Advance (en=1 at posedge clk_pix):
//   - sx wraps H_TOTAL-1 -> 0 and sy increments.
//   - sy wraps V_TOTAL-1 -> 0 only when sx also wraps.
//   - The first en=1 edge after reset produces (0,0) with frame=1, line=1.
//  Output registering:
//   - hsync/vsync/de/frame/line are registered, decoded from the next (sx,sy).
//   - Every output describes the same position as sx/sy in the same cycle; zero relative latency.
//  Decode:
//   - hsync active when H_RES+H_FP <= sx < H_RES+H_FP+H_SYNC.
//   - vsync active when V_RES+V_FP <= sy < V_RES+V_FP+V_SYNC.
//   - vsync transitions aligned to sx=0.
//  Hold (en=0):
//   - sx, sy, hsync, vsync, de hold.
//   - frame and line are forced to 0 after one cycle, so a strobe never exceeds one clk_pix cycle.
//  Arithmetic:
//   - Unsigned compares at CORDW bits; no signed or negative coordinates.
//   - Elaboration error if H_TOTAL or V_TOTAL exceeds 2**CORDW, or if H_BP or V_BP is 0.
//  Reset mid-frame: immediate return to the reset state; no partial-frame strobe is emitted.
// CONFIGURATION
//  DISPLAY_TIMINGS_FCNT_EN defined:
//   - Adds output frame_cnt [15:0]; reset 0.
//   - Increments, wrapping 65535 -> 0, in the same cycle frame asserts.
//  Not defined:
//   - Port absent; no counter logic.
// TESTING
//  1. Defaults, en=1 from reset -> frame=1 at first (0,0); next frame strobe 420000 cycles later (800x525).
//  2. Defaults -> hsync=0 exactly for sx 656..751.
//  3. Defaults -> vsync=0 exactly for sy 490..491.
//  4. Defaults -> de=1 for 640x480=307200 cycles per frame.
//  5. en toggled 1,0 repeating -> sx steps every 2 cycles; frame/line high 1 cycle only; positions held while en=0.
//  6. H_POL=1,V_POL=1, 1280x720 (FP 110/5, SYNC 40/5, BP 220/20, CORDW 11):
//     -> hsync=1 for sx 1390..1429; vsync=1 for sy 725..729; line period 1650.
//  7. rst pulsed at (300,200) -> sx=H_TOTAL-1, sy=V_TOTAL-1, de=0 immediately.
//     With FCNT_EN, frame_cnt=0, then 1 after the first frame strobe.

Source files
------------

// File: rtl/display_timings_param_if.sv
// Raster timing bundle between the timing source and its consumers.
// frame_cnt exists only when DISPLAY_TIMINGS_FCNT_EN is defined.
interface display_timings_param_if #(
  parameter int CORDW = 10
);
  logic             en;
  logic [CORDW-1:0] sx;
  logic [CORDW-1:0] sy;
  logic             hsync;
  logic             vsync;
  logic             de;
  logic             frame;
  logic             line;
`ifdef DISPLAY_TIMINGS_FCNT_EN
  logic [15:0]      frame_cnt;
`endif

  modport master (
    input  en,
    output sx, sy,
    output hsync, vsync, de,
`ifdef DISPLAY_TIMINGS_FCNT_EN
    output frame_cnt,
`endif
    output frame, line
  );

  modport slave (
    output en,
    input  sx, sy,
    input  hsync, vsync, de,
`ifdef DISPLAY_TIMINGS_FCNT_EN
    input  frame_cnt,
`endif
    input  frame, line
  );
endinterface

// File: rtl/display_timings_param.sv
// Parametrised raster timing generator with pixel-clock enable.
// Optional 16-bit frame counter under DISPLAY_TIMINGS_FCNT_EN.
module display_timings_param #(
  parameter int CORDW  = 10,
  parameter int H_RES  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_RES  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33,
  parameter bit H_POL  = 1'b0,
  parameter bit V_POL  = 1'b0
) (
  input logic                     clk_pix,
  input logic                     rst,
  display_timings_param_if.master tim
);

  localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > (2 ** CORDW)) begin : g_h_err
    $error("H_TOTAL does not fit in CORDW bits");
  end
  if (V_TOTAL > (2 ** CORDW)) begin : g_v_err
    $error("V_TOTAL does not fit in CORDW bits");
  end
  if (H_BP < 1) begin : g_hbp_err
    $error("H_BP must be at least 1");
  end
  if (V_BP < 1) begin : g_vbp_err
    $error("V_BP must be at least 1");
  end

  typedef logic [CORDW-1:0] coord_t;

  localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);
  localparam coord_t H_ACT  = coord_t'(H_RES);
  localparam coord_t V_ACT  = coord_t'(V_RES);
  localparam coord_t HS_ON  = coord_t'(H_RES + H_FP);
  localparam coord_t HS_OFF = coord_t'(H_RES + H_FP + H_SYNC);
  localparam coord_t VS_ON  = coord_t'(V_RES + V_FP);
  localparam coord_t VS_OFF = coord_t'(V_RES + V_FP + V_SYNC);
  localparam coord_t ONE    = coord_t'(1);

  coord_t sx_q, sx_d;
  coord_t sy_q, sy_d;
  logic   hs_q, hs_d;
  logic   vs_q, vs_d;
  logic   de_q, de_d;
  logic   fr_q, fr_d;
  logic   ln_q, ln_d;
  logic   h_wrap;

  // Outputs are decoded from the position about to be loaded,
  // so every registered flag lines up with sx/sy.
  always_comb begin
    h_wrap = (sx_q == H_LAST);
    sx_d   = h_wrap ? '0 : sx_q + ONE;
    sy_d   = sy_q;
    if (h_wrap) begin
      sy_d = (sy_q == V_LAST) ? '0 : sy_q + ONE;
    end
    hs_d = ((sx_d >= HS_ON) && (sx_d < HS_OFF)) ? H_POL : ~H_POL;
    vs_d = ((sy_d >= VS_ON) && (sy_d < VS_OFF)) ? V_POL : ~V_POL;
    de_d = (sx_d < H_ACT) && (sy_d < V_ACT);
    ln_d = (sx_d == '0);
    fr_d = (sx_d == '0) && (sy_d == '0);
  end

  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst) begin
      sx_q <= H_LAST;
      sy_q <= V_LAST;
      hs_q <= ~H_POL;
      vs_q <= ~V_POL;
      de_q <= 1'b0;
      fr_q <= 1'b0;
      ln_q <= 1'b0;
    end else if (tim.en) begin
      sx_q <= sx_d;
      sy_q <= sy_d;
      hs_q <= hs_d;
      vs_q <= vs_d;
      de_q <= de_d;
      fr_q <= fr_d;
      ln_q <= ln_d;
    end else begin
      // Strobes never outlive one clk_pix cycle while held.
      fr_q <= 1'b0;
      ln_q <= 1'b0;
    end
  end

  assign tim.sx    = sx_q;
  assign tim.sy    = sy_q;
  assign tim.hsync = hs_q;
  assign tim.vsync = vs_q;
  assign tim.de    = de_q;
  assign tim.frame = fr_q;
  assign tim.line  = ln_q;

`ifdef DISPLAY_TIMINGS_FCNT_EN
  logic [15:0] fcnt_q;

  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst) begin
      fcnt_q <= '0;
    end else if (tim.en && fr_d) begin
      fcnt_q <= fcnt_q + 16'd1;
    end
  end

  assign tim.frame_cnt = fcnt_q;
`endif

endmodule

// File: tb/tb_display_timings_param.sv
// Directed bench: small custom mode for frame-level checks,
// 1280x720 active-high mode for line-level checks.
module tb_display_timings_param;

  logic clk_pix = 1'b0;
  logic rst     = 1'b1;
  logic en      = 1'b0;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk_pix = ~clk_pix;

  display_timings_param_if #(.CORDW(6))  s_if ();
  display_timings_param_if #(.CORDW(11)) h_if ();

  assign s_if.en = en;
  assign h_if.en = en;

  // 24 x 16 total: hsync sx 18..20, vsync sy 12..13
  display_timings_param #(
    .CORDW(6),
    .H_RES(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_RES(10), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .H_POL(1'b0), .V_POL(1'b0)
  ) u_s (
    .clk_pix (clk_pix),
    .rst     (rst),
    .tim     (s_if)
  );

  display_timings_param #(
    .CORDW(11),
    .H_RES(1280), .H_FP(110), .H_SYNC(40), .H_BP(220),
    .V_RES(720),  .V_FP(5),   .V_SYNC(5),  .V_BP(20),
    .H_POL(1'b1), .V_POL(1'b1)
  ) u_h (
    .clk_pix (clk_pix),
    .rst     (rst),
    .tim     (h_if)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_pix);
    #1;
  endtask

  int s_de, s_hs, s_vs, s_ln, s_fr;
  int hs_min, hs_max, vs_min, vs_max;
  int vs_err, de_err, pos_err;
  int h_de, h_hs, h_vs, h_lfirst;
  int h_min, h_max;
  int pos, fl, ll;
  logic vs_prev;

  initial begin
    s_de = 0; s_hs = 0; s_vs = 0; s_ln = 0; s_fr = 0;
    hs_min = 999; hs_max = 0; vs_min = 999; vs_max = 0;
    vs_err = 0; de_err = 0; pos_err = 0;
    h_de = 0; h_hs = 0; h_vs = 0; h_lfirst = 0;
    h_min = 9999; h_max = 0;
    vs_prev = 1'b1;

    repeat (3) step();
    chk("rst_sx", 32'(s_if.sx), 32'd23);
    chk("rst_sy", 32'(s_if.sy), 32'd15);
    chk("rst_de", 32'(s_if.de), 32'd0);
    chk("rst_hs", 32'(s_if.hsync), 32'd1);
    chk("rst_vs", 32'(s_if.vsync), 32'd1);
    chk("rst_fr", 32'(s_if.frame), 32'd0);
    chk("rst_ln", 32'(s_if.line), 32'd0);
    chk("rst_hsx", 32'(h_if.sx), 32'd1649);
    chk("rst_hsy", 32'(h_if.sy), 32'd749);
    chk("rst_hhs", 32'(h_if.hsync), 32'd0);
    chk("rst_hvs", 32'(h_if.vsync), 32'd0);
`ifdef DISPLAY_TIMINGS_FCNT_EN
    chk("rst_fcnt", 32'(s_if.frame_cnt), 32'd0);
`endif

    en  = 1'b1;
    rst = 1'b0;
    step();
    chk("first_sx", 32'(s_if.sx), 32'd0);
    chk("first_sy", 32'(s_if.sy), 32'd0);
    chk("first_fr", 32'(s_if.frame), 32'd1);
    chk("first_ln", 32'(s_if.line), 32'd1);
    chk("first_de", 32'(s_if.de), 32'd1);
    chk("first_hfr", 32'(h_if.frame), 32'd1);
`ifdef DISPLAY_TIMINGS_FCNT_EN
    chk("fcnt_1", 32'(s_if.frame_cnt), 32'd1);
`endif

    for (int i = 0; i <= 1650; i++) begin
      if (i < 384) begin
        if (s_if.de) s_de++;
        if (s_if.de !== ((s_if.sx < 16) && (s_if.sy < 10)))
          de_err++;
        if (s_if.line) s_ln++;
        if (s_if.frame) s_fr++;
        if (!s_if.hsync) begin
          s_hs++;
          if (int'(s_if.sx) < hs_min) hs_min = int'(s_if.sx);
          if (int'(s_if.sx) > hs_max) hs_max = int'(s_if.sx);
        end
        if (!s_if.vsync) begin
          s_vs++;
          if (int'(s_if.sy) < vs_min) vs_min = int'(s_if.sy);
          if (int'(s_if.sy) > vs_max) vs_max = int'(s_if.sy);
        end
        if (i > 0 && s_if.vsync !== vs_prev && s_if.sx != 0)
          vs_err++;
        vs_prev = s_if.vsync;
      end
      if (i == 384) begin
        chk("f2_fr", 32'(s_if.frame), 32'd1);
        chk("f2_sx", 32'(s_if.sx), 32'd0);
        chk("f2_sy", 32'(s_if.sy), 32'd0);
`ifdef DISPLAY_TIMINGS_FCNT_EN
        chk("fcnt_2", 32'(s_if.frame_cnt), 32'd2);
`endif
      end
      if (i < 1650) begin
        if (h_if.de) h_de++;
        if (h_if.vsync) h_vs++;
        if (h_if.hsync) begin
          h_hs++;
          if (int'(h_if.sx) < h_min) h_min = int'(h_if.sx);
          if (int'(h_if.sx) > h_max) h_max = int'(h_if.sx);
        end
      end
      if (i > 0 && h_if.line && h_lfirst == 0) h_lfirst = i;
      step();
    end

    chk("s_de_cnt", 32'(s_de), 32'd160);
    chk("s_de_err", 32'(de_err), 32'd0);
    chk("s_hs_cnt", 32'(s_hs), 32'd48);
    chk("s_hs_min", 32'(hs_min), 32'd18);
    chk("s_hs_max", 32'(hs_max), 32'd20);
    chk("s_vs_cnt", 32'(s_vs), 32'd48);
    chk("s_vs_min", 32'(vs_min), 32'd12);
    chk("s_vs_max", 32'(vs_max), 32'd13);
    chk("s_vs_align", 32'(vs_err), 32'd0);
    chk("s_ln_cnt", 32'(s_ln), 32'd16);
    chk("s_fr_cnt", 32'(s_fr), 32'd1);
    chk("h_de_cnt", 32'(h_de), 32'd1280);
    chk("h_hs_cnt", 32'(h_hs), 32'd40);
    chk("h_hs_min", 32'(h_min), 32'd1390);
    chk("h_hs_max", 32'(h_max), 32'd1429);
    chk("h_vs_cnt", 32'(h_vs), 32'd0);
    chk("h_line_per", 32'(h_lfirst), 32'd1650);

    rst = 1'b1;
    repeat (2) step();
    en  = 1'b1;
    rst = 1'b0;
    step();
    chk("tg_fr0", 32'(s_if.frame), 32'd1);

    pos = 0; fl = 0; ll = 0;
    for (int k = 0; k < 30; k++) begin
      en = 1'b0;
      step();
      if (s_if.sx != 6'(pos % 24) || s_if.sy != 6'(pos / 24))
        pos_err++;
      fl += int'(s_if.frame);
      ll += int'(s_if.line);
      en = 1'b1;
      step();
      pos++;
      if (s_if.sx != 6'(pos % 24) || s_if.sy != 6'(pos / 24))
        pos_err++;
      fl += int'(s_if.frame);
      ll += int'(s_if.line);
    end
    chk("tg_pos_err", 32'(pos_err), 32'd0);
    chk("tg_fr_cnt", 32'(fl), 32'd0);
    chk("tg_ln_cnt", 32'(ll), 32'd1);
    chk("tg_sx", 32'(s_if.sx), 32'd6);
    chk("tg_sy", 32'(s_if.sy), 32'd1);

    repeat (100) step();
    chk("mid_sx", 32'(s_if.sx), 32'd10);
    chk("mid_sy", 32'(s_if.sy), 32'd5);
    chk("mid_de", 32'(s_if.de), 32'd1);

    #2 rst = 1'b1;
    #1;
    chk("arst_sx", 32'(s_if.sx), 32'd23);
    chk("arst_sy", 32'(s_if.sy), 32'd15);
    chk("arst_de", 32'(s_if.de), 32'd0);
    chk("arst_hs", 32'(s_if.hsync), 32'd1);
    chk("arst_fr", 32'(s_if.frame), 32'd0);
    chk("arst_ln", 32'(s_if.line), 32'd0);
`ifdef DISPLAY_TIMINGS_FCNT_EN
    chk("arst_fcnt", 32'(s_if.frame_cnt), 32'd0);
`endif
    repeat (2) step();
    chk("hold_rst_sx", 32'(s_if.sx), 32'd23);
    chk("hold_rst_fr", 32'(s_if.frame), 32'd0);
    rst = 1'b0;
    step();
    chk("post_sx", 32'(s_if.sx), 32'd0);
    chk("post_sy", 32'(s_if.sy), 32'd0);
    chk("post_fr", 32'(s_if.frame), 32'd1);
    chk("post_ln", 32'(s_if.line), 32'd1);
`ifdef DISPLAY_TIMINGS_FCNT_EN
    chk("post_fcnt", 32'(s_if.frame_cnt), 32'd1);
`endif
    step();
    chk("post_fr_off", 32'(s_if.frame), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
